// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the wait-state data memory.
// Sizes follow the CPU's funct3 low bits; 2'b11 is reserved and always rejected.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Lanes touched by a store; only meaningful for aligned accesses.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data across lanes so the mask alone selects the bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load path: picks the addressed lane(s) out of a memory word and extends to 32 bits.
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    value  = word;
    case (size)
      SZ_BYTE: value = {{24{sign_ext & lane_b[7]}}, lane_b};
      SZ_HALF: value = {{16{sign_ext & lane_h[15]}}, lane_h};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ws.sv
// Byte/half/word data memory with req/ready handshake and programmable wait states.
// The access itself happens on the edge that enters RESP; ready is high throughout RESP.
module data_mem_ws
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1,
  parameter bit RESET_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] pc_alu,
  input  logic [31:0] data_rt,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        misalign
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e        state, state_nxt;
  logic [3:0]    cnt;
  logic          go;
  logic          lat_write, lat_sext;
  logic [1:0]    lat_size;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_data;

  logic          op_write, op_sext, bad, mem_we;
  logic [1:0]    op_size, off;
  logic [AW+1:0] op_addr;
  logic [AW-1:0] idx;
  logic [3:0]    mask;
  logic [31:0]   op_data, rd_word, wr_bytes, wr_word, ld_value;
  logic [31:0]   mem [DEPTH_WORDS];

  // Addresses wrap modulo the memory size; the high bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^pc_alu[31:AW+2];

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      S_IDLE: if (req) begin
        if (WAIT_CYCLES == 0) begin
          state_nxt = S_RESP;
          go        = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: if (cnt == 4'd1) begin
        state_nxt = S_RESP;
        go        = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so bypass the latches.
  always_comb begin
    if (state == S_IDLE) begin
      op_write = MemWrite;
      op_size  = size;
      op_sext  = sign_ext;
      op_addr  = pc_alu[AW+1:0];
      op_data  = data_rt;
    end else begin
      op_write = lat_write;
      op_size  = lat_size;
      op_sext  = lat_sext;
      op_addr  = lat_addr;
      op_data  = lat_data;
    end
  end

  assign idx      = op_addr[AW+1:2];
  assign off      = op_addr[1:0];
  assign bad      = is_misaligned(op_size, off);
  assign mask     = lane_mask(op_size, off);
  assign wr_bytes = store_lanes(op_size, op_data);
  assign rd_word  = mem[idx];
  assign mem_we   = go && op_write && !bad;

  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) wr_word[8*i +: 8] = wr_bytes[8*i +: 8];
    end
  end

  dm_load_align u_load_align (
    .word     (rd_word),
    .off      (off),
    .size     (op_size),
    .sign_ext (op_sext),
    .value    (ld_value)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_size  <= SZ_BYTE;
      lat_sext  <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      data_out  <= '0;
      ready     <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready    <= go;
      misalign <= go && bad;
      if (state == S_IDLE && req) begin
        cnt       <= WAIT_INIT;
        lat_write <= MemWrite;
        lat_size  <= size;
        lat_sext  <= sign_ext;
        lat_addr  <= pc_alu[AW+1:0];
        lat_data  <= data_rt;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (go && !op_write && !bad) data_out <= ld_value;
    end
  end

  // NOTE: clearing the array on reset turns it into flops; the no-clear build keeps a plain RAM.
  if (RESET_CLEAR) begin : g_mem_clear
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      end else if (mem_we) begin
        mem[idx] <= wr_word;
      end
    end
  end else begin : g_mem_keep
    always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= wr_word;
    end
  end

endmodule
